// File: rtl/udma_eth_rx_packer_if.sv
// rtl/udma_eth_rx_packer_if.sv - byte-stream input and word-stream output bundle of the RX packer
// Signals:
//   s_axis_tdata/tvalid/tlast/tuser : byte stream from the MAC (no backpressure)
//   m_data_o/m_valid_o/m_ready_i    : word stream towards the uDMA RX channel
//   m_sof_o/m_last_o                : header / last-data-word markers for m_data_o
// Modports:
//   slave  : packer side (consumes bytes, produces words)
//   master : environment side (produces bytes, consumes words)
interface udma_eth_rx_packer_if;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        m_sof_o;
    logic        m_last_o;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_ready_i,
        output m_data_o, m_valid_o, m_sof_o, m_last_o
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_ready_i,
        input  m_data_o, m_valid_o, m_sof_o, m_last_o
    );
endinterface

// File: rtl/udma_eth_rx_packer.sv
// rtl/udma_eth_rx_packer.sv - store-and-forward RX byte-to-word packer with length headers
// Ports:
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   bus (slave)            : MAC byte stream in, header/data word stream out
//   good_frame_o           : 1-cycle pulse when a frame is committed
//   drop_bad_o             : 1-cycle pulse when a frame ends with tuser=1
//   drop_ovf_o             : 1-cycle pulse when a frame is dropped for lack of buffer space
//   drop_long_o            : 1-cycle pulse when a frame exceeds MAX_FRAME_BYTES
module udma_eth_rx_packer #(
    parameter int DEPTH_WORDS     = 512,
    parameter int MAX_FRAME_BYTES = 1536
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    udma_eth_rx_packer_if.slave  bus,
    output logic                 good_frame_o,
    output logic                 drop_bad_o,
    output logic                 drop_ovf_o,
    output logic                 drop_long_o
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH_WORDS);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [15:0] MAX_P   = 16'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DROP, S_COMMIT} state_e;

    state_e      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] wr_commit_q, wr_commit_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] pack_q, pack_d;
    logic        last_pend_q, last_pend_d;
    logic        drop_is_ovf_q, drop_is_ovf_d;
    logic        good_q, good_d, bad_q, bad_d, ovf_q, ovf_d, long_q, long_d;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic        wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0] wr_data;

    logic [AW:0] fill;
    logic        full;
    logic [1:0]  lane;
    logic [31:0] pack_nx;
    logic        need_wr;
    logic        word_ovf;
    logic [15:0] cnt_inc;

    logic [31:0] m_data_q;
    logic        m_valid_q, m_valid_d;
    logic        m_sof_q, m_sof_d;
    logic        m_last_q, m_last_d;
    logic [15:0] words_left_q, words_left_d;
    logic        readable;
    logic        rd_en;
    logic [15:0] hdr_words;
    logic [15:0] left_eff;

    assign fill = wr_ptr_q - rd_ptr_q;
    assign full = (fill == DEPTH_P);

    // ---------------- write side ----------------
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        wr_commit_d   = wr_commit_q;
        byte_cnt_d    = byte_cnt_q;
        pack_d        = pack_q;
        last_pend_d   = 1'b0;
        drop_is_ovf_d = drop_is_ovf_q;
        good_d        = 1'b0;
        bad_d         = 1'b0;
        ovf_d         = 1'b0;
        long_d        = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = wr_ptr_q[AW-1:0];
        wr_data       = pack_q;

        lane    = byte_cnt_q[1:0];
        cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
        // Lane 0 opens a fresh word, so stale upper lanes never leak into a padded tail word.
        if (lane == 2'd0) begin
            pack_nx = {24'h0, bus.s_axis_tdata};
        end else begin
            pack_nx = pack_q;
            pack_nx[{lane, 3'b000} +: 8] = bus.s_axis_tdata;
        end
        need_wr  = (lane == 2'd3) || (bus.s_axis_tlast && !bus.s_axis_tuser);
        word_ovf = need_wr && full;

        unique case (state_q)
            S_IDLE, S_COMMIT: begin
                if (state_q == S_COMMIT) begin
                    wr_en       = 1'b1;
                    wr_addr     = wr_commit_q[AW-1:0];
                    wr_data     = {16'h0, byte_cnt_q};
                    wr_commit_d = wr_ptr_q;
                    good_d      = 1'b1;
                    state_d     = S_IDLE;
                end
                // Here wr_ptr_q already equals the next header slot, so it is reserved by
                // advancing wr_ptr past it.
                if (bus.s_axis_tvalid) begin
                    byte_cnt_d = 16'd1;
                    if (full) begin
                        drop_is_ovf_d = 1'b1;
                        if (bus.s_axis_tlast) begin
                            ovf_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (bus.s_axis_tlast && bus.s_axis_tuser) begin
                        bad_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        pack_d      = {24'h0, bus.s_axis_tdata};
                        wr_ptr_d    = wr_ptr_q + PTR_ONE;
                        // A single-byte frame cannot write its data word in a COMMIT cycle
                        // (the header owns the write port); flush it on the next cycle.
                        last_pend_d = bus.s_axis_tlast;
                        state_d     = S_PACK;
                    end
                end
            end
            S_PACK: begin
                if (last_pend_q) begin
                    // Flush cycle of a single-byte frame; the MAC inter-frame gap means no
                    // byte arrives here.
                    if (full) begin
                        ovf_d    = 1'b1;
                        wr_ptr_d = wr_commit_q;
                        state_d  = S_IDLE;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        state_d  = S_COMMIT;
                    end
                end else if (bus.s_axis_tvalid) begin
                    if (word_ovf || (byte_cnt_q >= MAX_P)) begin
                        byte_cnt_d = cnt_inc;
                        if (bus.s_axis_tlast) begin
                            ovf_d    = word_ovf;
                            long_d   = !word_ovf;
                            wr_ptr_d = wr_commit_q;
                            state_d  = S_IDLE;
                        end else begin
                            drop_is_ovf_d = word_ovf;
                            state_d       = S_DROP;
                        end
                    end else if (bus.s_axis_tlast && bus.s_axis_tuser) begin
                        bad_d    = 1'b1;
                        wr_ptr_d = wr_commit_q;
                        state_d  = S_IDLE;
                    end else begin
                        pack_d     = pack_nx;
                        byte_cnt_d = cnt_inc;
                        if (need_wr) begin
                            wr_en    = 1'b1;
                            wr_data  = pack_nx;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                        end
                        if (bus.s_axis_tlast) begin
                            state_d = S_COMMIT;
                        end
                    end
                end
            end
            S_DROP: begin
                if (bus.s_axis_tvalid) begin
                    byte_cnt_d = cnt_inc;
                    if (bus.s_axis_tlast) begin
                        ovf_d    = drop_is_ovf_q;
                        long_d   = !drop_is_ovf_q;
                        wr_ptr_d = wr_commit_q;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            byte_cnt_q    <= '0;
            pack_q        <= '0;
            last_pend_q   <= 1'b0;
            drop_is_ovf_q <= 1'b0;
            good_q        <= 1'b0;
            bad_q         <= 1'b0;
            ovf_q         <= 1'b0;
            long_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_commit_q   <= wr_commit_d;
            byte_cnt_q    <= byte_cnt_d;
            pack_q        <= pack_d;
            last_pend_q   <= last_pend_d;
            drop_is_ovf_q <= drop_is_ovf_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
            ovf_q         <= ovf_d;
            long_q        <= long_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // ---------------- read side ----------------
    assign readable  = (rd_ptr_q != wr_commit_q);
    assign rd_en     = readable && (!m_valid_q || bus.m_ready_i);
    assign hdr_words = 16'(({1'b0, m_data_q[15:0]} + 17'd3) >> 2);
    // While the header still sits in the output register its length seeds the data count.
    assign left_eff  = m_sof_q ? hdr_words : words_left_q;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        m_valid_d    = m_valid_q;
        m_sof_d      = m_sof_q;
        m_last_d     = m_last_q;
        words_left_d = words_left_q;
        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            m_valid_d = 1'b1;
            if (!m_sof_q && (words_left_q == 16'd0)) begin
                m_sof_d  = 1'b1;
                m_last_d = 1'b0;
            end else begin
                m_sof_d      = 1'b0;
                m_last_d     = (left_eff == 16'd1);
                words_left_d = left_eff - 16'd1;
            end
        end else if (bus.m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q     <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_sof_q      <= 1'b0;
            m_last_q     <= 1'b0;
            words_left_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            m_valid_q    <= m_valid_d;
            m_sof_q      <= m_sof_d;
            m_last_q     <= m_last_d;
            words_left_q <= words_left_d;
            if (rd_en) begin
                m_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    assign bus.m_data_o  = m_data_q;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_sof_o   = m_sof_q & m_valid_q;
    assign bus.m_last_o  = m_last_q & m_valid_q;
    assign good_frame_o  = good_q;
    assign drop_bad_o    = bad_q;
    assign drop_ovf_o    = ovf_q;
    assign drop_long_o   = long_q;
endmodule

// File: tb/tb_udma_eth_rx_packer.sv
// tb/tb_udma_eth_rx_packer.sv - scoreboard testbench for udma_eth_rx_packer
module tb_udma_eth_rx_packer;
    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    logic good_frame_o, drop_bad_o, drop_ovf_o, drop_long_o;

    udma_eth_rx_packer_if bus ();

    udma_eth_rx_packer #(
        .DEPTH_WORDS     (512),
        .MAX_FRAME_BYTES (1536)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .bus          (bus),
        .good_frame_o (good_frame_o),
        .drop_bad_o   (drop_bad_o),
        .drop_ovf_o   (drop_ovf_o),
        .drop_long_o  (drop_long_o)
    );

    always #4 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_good   = 0;
    int n_bad    = 0;
    int n_ovf    = 0;
    int n_long   = 0;
    bit rand_ready = 1'b0;
    logic [33:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(input int len, input logic [7:0] seed);
        int nw;
        logic [31:0] w;
        logic [7:0] b;
        exp_q.push_back({2'b10, 16'h0, 16'(len)});
        nw = (len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                if (i * 4 + k < len) begin
                    b = 8'(int'(seed) + i * 4 + k);
                    w[k*8 +: 8] = b;
                end
            end
            exp_q.push_back({1'b0, (i == nw - 1), w});
        end
    endfunction

    // Leaves the last byte driven so a following frame can start in the very next cycle.
    task automatic send_bytes(input int len, input logic [7:0] seed, input bit bad, input bit with_last);
        for (int i = 0; i < len; i++) begin
            @(posedge clk_i); #1;
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = 8'(int'(seed) + i);
            bus.s_axis_tlast  = with_last && (i == len - 1);
            bus.s_axis_tuser  = bad && with_last && (i == len - 1);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i); #1;
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tlast  = 1'b0;
            bus.s_axis_tuser  = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.m_valid_o) && t < 20000) begin
            @(negedge clk_i);
            t++;
        end
        check(tag, 64'(t < 20000), 64'd1);
        idle(6);
    endtask

    always @(negedge clk_i) begin
        if (rstn_i) begin
            n_good += int'(good_frame_o);
            n_bad  += int'(drop_bad_o);
            n_ovf  += int'(drop_ovf_o);
            n_long += int'(drop_long_o);
            if (bus.m_valid_o && bus.m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {30'h0, bus.m_sof_o, bus.m_last_o, bus.m_data_o}, 64'h3_0000_0000);
                end else begin
                    check("word", {30'h0, bus.m_sof_o, bus.m_last_o, bus.m_data_o}, {30'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i); #1;
            if (rand_ready) bus.m_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, b0, o0, l0, len, gap;
        logic [7:0] seed;
        bus.s_axis_tdata  = 8'h0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        bus.m_ready_i     = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 64'(bus.m_valid_o), 64'd0);
        check("rst_data", 64'(bus.m_data_o), 64'd0);
        check("rst_sof_last", 64'({bus.m_sof_o, bus.m_last_o}), 64'd0);
        check("rst_pulses", 64'({good_frame_o, drop_bad_o, drop_ovf_o, drop_long_o}), 64'd0);
        @(posedge clk_i); #1 rstn_i = 1'b1;

        // 64-byte frame 00..3F
        g0 = n_good;
        push_frame(64, 8'h00); send_bytes(64, 8'h00, 1'b0, 1'b1); idle(2);
        drain("f64_drain");
        check("f64_good", 64'(n_good - g0), 64'd1);

        // 61-byte frame: zero-padded tail word
        g0 = n_good;
        push_frame(61, 8'h00); send_bytes(61, 8'h00, 1'b0, 1'b1); idle(2);
        drain("f61_drain");
        check("f61_good", 64'(n_good - g0), 64'd1);

        // bad frame followed by good frame
        g0 = n_good; b0 = n_bad;
        send_bytes(100, 8'h40, 1'b1, 1'b1); idle(3);
        push_frame(64, 8'h00); send_bytes(64, 8'h00, 1'b0, 1'b1); idle(2);
        drain("bad_drain");
        check("bad_pulse", 64'(n_bad - b0), 64'd1);
        check("bad_good", 64'(n_good - g0), 64'd1);

        // overflow with consumer stalled
        g0 = n_good; o0 = n_ovf;
        bus.m_ready_i = 1'b0;
        push_frame(1000, 8'h11); send_bytes(1000, 8'h11, 1'b0, 1'b1); idle(4);
        push_frame(1000, 8'h22); send_bytes(1000, 8'h22, 1'b0, 1'b1); idle(4);
        send_bytes(1000, 8'h33, 1'b0, 1'b1); idle(10);
        @(negedge clk_i);
        check("ovf_good", 64'(n_good - g0), 64'd2);
        check("ovf_pulse", 64'(n_ovf - o0), 64'd1);
        check("ovf_hold_hdr", {31'h0, bus.m_valid_o, bus.m_sof_o, bus.m_data_o}, {31'h0, 2'b11, 32'h3E8});
        @(posedge clk_i); #1 bus.m_ready_i = 1'b1;
        drain("ovf_drain");

        // overlong frame, then the longest allowed frame
        g0 = n_good; l0 = n_long;
        send_bytes(1537, 8'h05, 1'b0, 1'b1); idle(3);
        push_frame(1536, 8'h07); send_bytes(1536, 8'h07, 1'b0, 1'b1); idle(2);
        drain("long_drain");
        check("long_pulse", 64'(n_long - l0), 64'd1);
        check("long_good", 64'(n_good - g0), 64'd1);

        // two 5-byte frames back to back
        g0 = n_good;
        push_frame(5, 8'hA0); push_frame(5, 8'hB0);
        send_bytes(5, 8'hA0, 1'b0, 1'b1); send_bytes(5, 8'hB0, 1'b0, 1'b1); idle(3);
        drain("b2b_drain");
        check("b2b_good", 64'(n_good - g0), 64'd2);

        // reset in the middle of a frame
        send_bytes(30, 8'h60, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        rstn_i = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        check("mid_rst_valid", 64'(bus.m_valid_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        idle(3);
        g0 = n_good;
        push_frame(20, 8'hC0); send_bytes(20, 8'hC0, 1'b0, 1'b1); idle(2);
        drain("rst_drain");
        check("rst_good", 64'(n_good - g0), 64'd1);

        // random lengths and gaps with a random consumer
        g0 = n_good;
        rand_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            len  = (f == 0) ? 1 : int'($urandom_range(1, 200));
            seed = 8'($urandom_range(0, 255));
            gap  = (len == 1) ? 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
            push_frame(len, seed);
            send_bytes(len, seed, 1'b0, 1'b1);
            idle(gap);
        end
        idle(2);
        drain("rand_drain");
        rand_ready = 1'b0;
        @(posedge clk_i); #2 bus.m_ready_i = 1'b1;
        drain("rand_tail");
        check("rand_good", 64'(n_good - g0), 64'd10);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
